// File: rtl/probe_sequencer.sv
// probe_sequencer: arms a logic probe, reads its result words after each
// trigger and publishes them to a CPU-visible readout bank with an interrupt.
module probe_sequencer #(
    parameter int WORDS          = 8,
    parameter int RESET_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        req,
    input  logic        nwr,
    input  logic [3:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        interrupt,
    input  logic        interrupt_clear,
    output logic        probe_nreset,
    output logic [2:0]  probe_address,
    output logic        probe_data_request,
    input  logic        probe_data_ready,
    input  logic [31:0] probe_data,
    input  logic        probe_interrupt,
    output logic        probe_interrupt_clear
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PRESET  = 3'd1;
    localparam logic [2:0] ARM     = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_REL  = 3'd4;
    localparam logic [2:0] CLR     = 3'd5;
    localparam logic [2:0] PUBLISH = 3'd6;

    localparam int TMAX = (RESET_CYCLES > TIMEOUT_CYCLES) ?
                          RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [TW-1:0] PRESET_LAST = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_SAT     = '1;
    localparam logic [2:0]    LAST_IDX    = 3'(WORDS - 1);
    localparam logic [3:0]    NWORDS      = 4'(WORDS);
    localparam logic [3:0]    CTL_ADDR    = 4'd8;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [TW-1:0] tmr;
    logic [2:0]    idx;
    logic [2:0]    idx_nxt;

    logic          rdy_s1;
    logic          rdy_s2;
    logic          pint_s1;
    logic          pint_s2;

    logic          enable;
    logic          error;
    logic [15:0]   capture_count;

    logic [31:0]   cap  [8];
    logic [31:0]   bank [8];

    logic          fire;
    logic          wr_ctl;
    logic          start;
    logic          tmo_hit;
    logic          tmo;
    logic          cap_we;
    logic          publish;
    logic          busy;
    logic [31:0]   status;
    logic [31:0]   rd_val;

    assign fire    = req & ~ack;
    assign wr_ctl  = fire & ~nwr & (address == CTL_ADDR);
    assign start   = wr_ctl & data_in[0] & ~enable;
    assign tmo_hit = (tmr == TMO_LAST);
    assign publish = (state == PUBLISH);
    assign busy    = (state != IDLE);
    assign status  = {12'h0, capture_count, error, interrupt, busy, enable};

    // Two-flop synchronizers for the asynchronous probe handshake inputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdy_s1  <= 1'b0;
            rdy_s2  <= 1'b0;
            pint_s1 <= 1'b0;
            pint_s2 <= 1'b0;
        end else begin
            rdy_s1  <= probe_data_ready;
            rdy_s2  <= rdy_s1;
            pint_s1 <= probe_interrupt;
            pint_s2 <= pint_s1;
        end
    end

    // Next-state decode; a handshake timeout overrides every other transition
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cap_we    = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = PRESET;
            end
            PRESET: begin
                if (tmr == PRESET_LAST) state_nxt = ARM;
            end
            ARM: begin
                if (pint_s2) begin
                    idx_nxt   = 3'd0;
                    state_nxt = RD_REQ;
                end else if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                if (rdy_s2) begin
                    cap_we    = 1'b1;
                    state_nxt = RD_REL;
                end else if (tmo_hit) begin
                    tmo = 1'b1;
                end
            end
            RD_REL: begin
                if (!rdy_s2) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = CLR;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = RD_REQ;
                    end
                end else if (tmo_hit) begin
                    tmo = 1'b1;
                end
            end
            CLR: begin
                if (!pint_s2) state_nxt = PUBLISH;
                else if (tmo_hit) tmo = 1'b1;
            end
            PUBLISH: begin
                state_nxt = (enable | start) ? ARM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (tmo) state_nxt = IDLE;
    end

    // State, per-state timer (cleared on entry) and word index
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            tmr   <= '0;
            idx   <= 3'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (state_nxt != state) tmr <= '0;
            else if (tmr != TMR_SAT) tmr <= tmr + 1'b1;
        end
    end

    // Probe strobes registered from the next state so they are glitch-free
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            probe_nreset          <= 1'b0;
            probe_data_request    <= 1'b0;
            probe_interrupt_clear <= 1'b0;
            probe_address         <= 3'd0;
        end else begin
            probe_nreset          <= (state_nxt != IDLE) &&
                                     (state_nxt != PRESET);
            probe_data_request    <= (state_nxt == RD_REQ);
            probe_interrupt_clear <= (state_nxt == CLR);
            probe_address         <= idx_nxt;
        end
    end

    // Capture buffer, written once per word when synchronized ready rises
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 8; i++) cap[i] <= '0;
        end else if (cap_we) begin
            cap[idx] <= probe_data;
        end
    end

    // Readout bank: whole capture copied in one cycle so reads never tear
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else if (publish) begin
            for (int i = 0; i < 8; i++) begin
                if (i < WORDS) bank[i] <= cap[i];
            end
        end
    end

    // Control/status: enable, error, capture counter and CPU interrupt
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            enable        <= 1'b0;
            error         <= 1'b0;
            interrupt     <= 1'b0;
            capture_count <= 16'h0;
        end else begin
            if (tmo) enable <= 1'b0;
            else if (wr_ctl) enable <= data_in[0];

            if (tmo) error <= 1'b1;
            else if (start && state == IDLE) error <= 1'b0;

            if (publish) interrupt <= 1'b1;
            else if (interrupt_clear) interrupt <= 1'b0;

            if (publish) capture_count <= capture_count + 16'h1;
        end
    end

    // Read mux for the CPU register map
    always_comb begin
        rd_val = 32'h0;
        if (address < NWORDS) rd_val = bank[address[2:0]];
        else if (address == CTL_ADDR) rd_val = status;
    end

    // CPU handshake: one action per req assertion, data held while ack high
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ack      <= 1'b0;
            data_out <= 32'h0;
        end else begin
            ack <= req;
            if (fire) data_out <= rd_val;
        end
    end

endmodule

// File: tb/tb_probe_sequencer.sv
// tb_probe_sequencer: directed bench for probe_sequencer with a simple
// behavioural probe that answers reads with base+address.
module tb_probe_sequencer;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        req = 1'b0;
    logic        nwr = 1'b1;
    logic [3:0]  address = 4'd0;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        ack;
    logic        interrupt;
    logic        interrupt_clear = 1'b0;
    logic        probe_nreset;
    logic [2:0]  probe_address;
    logic        probe_data_request;
    logic        probe_data_ready;
    logic [31:0] probe_data;
    logic        probe_interrupt;
    logic        probe_interrupt_clear;

    logic        hang = 1'b0;
    logic        clr_seen = 1'b0;
    logic [31:0] base = 32'h0;

    int errors = 0;
    int checks = 0;

    probe_sequencer dut (
        .clk                   (clk),
        .nreset                (nreset),
        .req                   (req),
        .nwr                   (nwr),
        .address               (address),
        .data_in               (data_in),
        .data_out              (data_out),
        .ack                   (ack),
        .interrupt             (interrupt),
        .interrupt_clear       (interrupt_clear),
        .probe_nreset          (probe_nreset),
        .probe_address         (probe_address),
        .probe_data_request    (probe_data_request),
        .probe_data_ready      (probe_data_ready),
        .probe_data            (probe_data),
        .probe_interrupt       (probe_interrupt),
        .probe_interrupt_clear (probe_interrupt_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input logic lvl);
        int t;
        t = 0;
        while (ack !== lvl && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (ack !== lvl) chk("ack_timeout", {31'b0, ack}, {31'b0, lvl});
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
        req = 1'b1;
        nwr = 1'b1;
        address = a;
        wait_ack(1'b1);
        d = data_out;
        req = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        req = 1'b1;
        nwr = 1'b0;
        address = a;
        data_in = d;
        wait_ack(1'b1);
        req = 1'b0;
        nwr = 1'b1;
        wait_ack(1'b0);
    endtask

    task automatic pulse_clear();
        interrupt_clear = 1'b1;
        @(negedge clk);
        interrupt_clear = 1'b0;
    endtask

    // Behavioural probe: answers requests, drops interrupt when cleared
    initial begin
        probe_data_ready = 1'b0;
        probe_data = 32'h0;
        probe_interrupt = 1'b0;
        forever begin
            @(negedge clk);
            if (!probe_nreset) begin
                probe_data_ready = 1'b0;
                probe_interrupt = 1'b0;
            end else begin
                if (probe_data_request && !(hang && probe_address == 3'd3)) begin
                    if (!probe_data_ready) begin
                        probe_data = base + {29'b0, probe_address};
                        probe_data_ready = 1'b1;
                    end
                end else if (!probe_data_request) begin
                    probe_data_ready = 1'b0;
                end
                if (probe_interrupt_clear) begin
                    clr_seen = 1'b1;
                    probe_interrupt = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic prev;
        logic seen;
        int n;

        repeat (3) @(negedge clk);
        chk("rst_outs", {25'b0, ack, interrupt, probe_nreset,
            probe_data_request, probe_interrupt_clear, probe_address}, 32'h0);
        chk("rst_dout", data_out, 32'h0);
        nreset = 1'b1;
        @(negedge clk);
        cpu_read(4'd8, d);
        chk("rst_status", d, 32'h0);

        req = 1'b1;
        nwr = 1'b0;
        address = 4'd8;
        data_in = 32'h1;
        wait_ack(1'b1);
        n = 0;
        while (!probe_nreset && n < 100) begin
            req = 1'b0;
            nwr = 1'b1;
            n++;
            @(negedge clk);
        end
        req = 1'b0;
        nwr = 1'b1;
        wait_ack(1'b0);
        chk("preset_len", 32'(n), 32'd16);
        cpu_read(4'd8, d);
        chk("status_armed", d, 32'h3);
        cpu_write(4'd3, 32'hdead);
        cpu_read(4'd3, d);
        chk("ignored_wr", d, 32'h0);

        base = 32'h100;
        clr_seen = 1'b0;
        probe_interrupt = 1'b1;
        n = 0;
        while (!interrupt && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("cap1_irq", {31'b0, interrupt}, 32'h1);
        chk("cap1_clr", {30'b0, clr_seen, probe_interrupt}, 32'h2);
        for (int i = 0; i < 8; i++) begin
            cpu_read(4'(i), d);
            chk("cap1_word", d, 32'h100 + 32'(i));
        end
        cpu_read(4'd8, d);
        chk("cap1_status", d, 32'h17);
        cpu_read(4'd9, d);
        chk("addr9_zero", d, 32'h0);
        pulse_clear();
        chk("irq_cleared", {31'b0, interrupt}, 32'h0);

        base = 32'h200;
        probe_interrupt = 1'b1;
        n = 0;
        while (!probe_data_request && n < 100) begin
            @(negedge clk);
            n++;
        end
        cpu_read(4'd0, d);
        chk("old_during_cap", d, 32'h100);
        prev = 1'b0;
        n = 0;
        while (n < 500) begin
            if (prev && !probe_interrupt_clear) break;
            prev = probe_interrupt_clear;
            @(negedge clk);
            n++;
        end
        chk("pub_seen", {31'b0, n < 500}, 32'h1);
        pulse_clear();
        chk("irq_set_wins", {31'b0, interrupt}, 32'h1);
        pulse_clear();
        chk("irq_later_clr", {31'b0, interrupt}, 32'h0);
        cpu_read(4'd0, d);
        chk("cap2_w0", d, 32'h200);
        cpu_read(4'd7, d);
        chk("cap2_w7", d, 32'h207);
        cpu_read(4'd8, d);
        chk("cap2_status", d, 32'h23);

        hang = 1'b1;
        base = 32'h300;
        probe_interrupt = 1'b1;
        n = 0;
        while (!(probe_data_request && probe_address == 3'd3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (probe_data_request && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_len", 32'(n), 32'd1024);
        repeat (2) @(negedge clk);
        chk("tmo_probe_rst", {31'b0, probe_nreset}, 32'h0);
        cpu_read(4'd8, d);
        chk("tmo_status", d, 32'h28);
        cpu_read(4'd0, d);
        chk("tmo_keep_w0", d, 32'h200);
        cpu_read(4'd3, d);
        chk("tmo_keep_w3", d, 32'h203);

        hang = 1'b0;
        cpu_write(4'd8, 32'h1);
        cpu_read(4'd8, d);
        chk("reen_status", d, 32'h23);
        n = 0;
        while (!probe_nreset && n < 100) begin
            @(negedge clk);
            n++;
        end
        base = 32'h400;
        probe_interrupt = 1'b1;
        seen = 1'b0;
        n = 0;
        while (n < 500) begin
            if (probe_address == 3'd5 && probe_data_request) seen = 1'b1;
            else if (seen && !probe_data_request) break;
            @(negedge clk);
            n++;
        end
        chk("rdrel5_seen", {31'b0, seen}, 32'h1);
        nreset = 1'b0;
        #1;
        chk("mid_rst_outs", {25'b0, ack, interrupt, probe_nreset,
            probe_data_request, probe_interrupt_clear, probe_address}, 32'h0);
        chk("mid_rst_dout", data_out, 32'h0);
        @(negedge clk);
        nreset = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_rst_noirq", {31'b0, interrupt}, 32'h0);
        cpu_read(4'd8, d);
        chk("mid_rst_status", d, 32'h0);
        cpu_read(4'd5, d);
        chk("mid_rst_bank", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
